// File: rtl/sb_game_ctrl.sv
// -----------------------------------------------------------------------------
// sb_game_ctrl
//  Game sequencer for the small-ball game. Takes goal/lose events from the
//  display and drives run/serve, the ball and bar speeds, and the score, lives
//  and level counters. The FSM steps through IDLE -> SERVE (countdown) -> PLAY
//  -> OVER (hold) -> IDLE.
//
//  Optional feature macro: SBG_PAUSE_EN
//   When defined, adds a `pause` level input. A rising edge of `pause` in PLAY
//   freezes the game (run=0, goal/lose ignored, state output stays PLAY). The
//   next rising edge of `pause` resumes play.
//
//  Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   frame_tick     1-cycle pulse once per video frame
//   start          level input; only its rising edge is used
//   hard           hard mode, captured on IDLE->SERVE
//   goal / lose    1-cycle event pulses from the display
//   pause          (SBG_PAUSE_EN only) pause toggle, rising-edge sensitive
//   bar_move_speed user bar speed
//   run            high in PLAY (and not paused)
//   serve          1-cycle pulse on SERVE->PLAY
//   ball_speed     min(1 + level + (hard_q ? 2 : 0), 15), combinational
//   bar_speed      bar_move_speed with 0 forced to 1, combinational
//   score          goals this game, saturating
//   lives          remaining lives
//   level          current level, 0..MAX_LEVEL
//   game_over      high in OVER
//   state          IDLE=0, SERVE=1, PLAY=2, OVER=3
// -----------------------------------------------------------------------------
module sb_game_ctrl #(
  parameter int LIVES_INIT   = 3,
  parameter int SCORE_W      = 14,
  parameter int LEVEL_STEP   = 10,
  parameter int MAX_LEVEL    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               hard,
  input  logic               goal,
  input  logic               lose,
`ifdef SBG_PAUSE_EN
  input  logic               pause,
`endif
  input  logic [3:0]         bar_move_speed,
  output logic               run,
  output logic               serve,
  output logic [3:0]         ball_speed,
  output logic [3:0]         bar_speed,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic [2:0]         level,
  output logic               game_over,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  // One frame counter serves both the SERVE countdown and the OVER hold.
  localparam int FC_MAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
  localparam int FC_W   = (FC_MAX > 2) ? $clog2(FC_MAX) : 1;
  localparam int LC_W   = (LEVEL_STEP > 2) ? $clog2(LEVEL_STEP) : 1;

  localparam logic [FC_W-1:0]    SERVE_LAST = FC_W'(SERVE_FRAMES - 1);
  localparam logic [FC_W-1:0]    OVER_LAST  = FC_W'(OVER_FRAMES - 1);
  localparam logic [LC_W-1:0]    LVL_LAST   = LC_W'(LEVEL_STEP - 1);
  localparam logic [2:0]         LEVEL_TOP  = 3'(MAX_LEVEL);
  localparam logic [SCORE_W-1:0] SCORE_TOP  = '1;

  state_t            state_q, state_d;
  logic              start_q;
  logic              hard_q;
  logic [FC_W-1:0]   frame_cnt;
  logic [LC_W-1:0]   lvl_cnt;

  logic              rise;
  logic              play_active;
  logic              goal_ev, lose_ev;
  logic              game_start, serve_d, fc_clr, fc_inc;
  logic              paused_q, paused_d;

  assign rise = start & ~start_q;

`ifdef SBG_PAUSE_EN
  logic pause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pause_q  <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      pause_q  <= pause;
      paused_q <= paused_d;
    end
  end

  // Pause toggles only while in PLAY; leaving PLAY always clears it.
  always_comb begin
    paused_d = paused_q;
    if (state_q == PLAY && pause && !pause_q) paused_d = ~paused_q;
    if (state_d != PLAY) paused_d = 1'b0;
  end
`else
  assign paused_q = 1'b0;
  assign paused_d = 1'b0;
`endif

  assign play_active = (state_q == PLAY) && !paused_q;
  // A simultaneous lose wins: the goal in that cycle is dropped.
  assign goal_ev     = play_active & goal & ~lose;
  assign lose_ev     = play_active & lose;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    game_start = 1'b0;
    serve_d    = 1'b0;
    fc_clr     = 1'b0;
    fc_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = SERVE;
          game_start = 1'b1;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (frame_cnt == SERVE_LAST) begin
            state_d = PLAY;
            serve_d = 1'b1;
            fc_clr  = 1'b1;
          end else begin
            fc_inc = 1'b1;
          end
        end
      end
      PLAY: begin
        if (lose_ev) begin
          state_d = (lives == 2'd1) ? OVER : SERVE;
          fc_clr  = 1'b1;
        end
      end
      OVER: begin
        if (frame_tick) begin
          if (frame_cnt == OVER_LAST) begin
            state_d = IDLE;
            fc_clr  = 1'b1;
          end else begin
            fc_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q   <= 1'b0;
      hard_q    <= 1'b0;
      frame_cnt <= '0;
      lvl_cnt   <= '0;
      score     <= '0;
      lives     <= 2'd0;
      level     <= 3'd0;
      run       <= 1'b0;
      serve     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      start_q   <= start;
      run       <= (state_d == PLAY) && !paused_d;
      serve     <= serve_d;
      game_over <= (state_d == OVER);

      if (fc_clr || game_start) frame_cnt <= '0;
      else if (fc_inc)          frame_cnt <= frame_cnt + 1'b1;

      if (game_start) begin
        score   <= '0;
        level   <= 3'd0;
        lvl_cnt <= '0;
        hard_q  <= hard;
        lives   <= hard ? 2'd1 : 2'(LIVES_INIT);
      end

      if (goal_ev) begin
        if (score != SCORE_TOP) score <= score + 1'b1;
        if (lvl_cnt == LVL_LAST) begin
          lvl_cnt <= '0;
          if (level != LEVEL_TOP) level <= level + 3'd1;
        end else begin
          lvl_cnt <= lvl_cnt + 1'b1;
        end
      end

      if (lose_ev) lives <= lives - 2'd1;
    end
  end

  // Speeds: sum in 5 bits so the clamp sees any overflow past 15.
  logic [4:0] speed_sum;
  assign speed_sum  = 5'd1 + {2'b00, level} + (hard_q ? 5'd2 : 5'd0);
  assign ball_speed = (speed_sum > 5'd15) ? 4'd15 : speed_sum[3:0];
  assign bar_speed  = (bar_move_speed == 4'd0) ? 4'd1 : bar_move_speed;

  assign state = state_q;

endmodule

// File: tb/tb_sb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sb_game_ctrl
//  Directed self-checking bench for sb_game_ctrl with hand-computed
//  expectations: reset, serve countdown, scoring/levels, goal+lose collision,
//  hard-mode game over and hold, bar speed clamp and mid-play reset.
// -----------------------------------------------------------------------------
module tb_sb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst, frame_tick, start, hard, goal, lose;
  logic [3:0]  bar_move_speed;
  logic        run, serve, game_over;
  logic [3:0]  ball_speed, bar_speed;
  logic [13:0] score;
  logic [1:0]  lives, state;
  logic [2:0]  level;
`ifdef SBG_PAUSE_EN
  logic        pause = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  sb_game_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .start          (start),
    .hard           (hard),
    .goal           (goal),
    .lose           (lose),
`ifdef SBG_PAUSE_EN
    .pause          (pause),
`endif
    .bar_move_speed (bar_move_speed),
    .run            (run),
    .serve          (serve),
    .ball_speed     (ball_speed),
    .bar_speed      (bar_speed),
    .score          (score),
    .lives          (lives),
    .level          (level),
    .game_over      (game_over),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0; tick();
    end
  endtask

  task automatic pulse_goal(input int n);
    for (int i = 0; i < n; i++) begin
      goal = 1'b1; tick();
      goal = 1'b0;
    end
  endtask

  task automatic start_game(input logic h);
    hard  = h;
    start = 1'b1; tick();
    start = 1'b0; tick();
  endtask

  // Runs the 60-frame countdown and checks the serve pulse and PLAY entry.
  task automatic do_serve(input string tag);
    frames(59);
    check({tag, " state before last frame"}, 32'(state), 32'd1);
    check({tag, " serve before last frame"}, 32'(serve), 32'd0);
    frame_tick = 1'b1; tick();
    frame_tick = 1'b0;
    check({tag, " serve pulse"}, 32'(serve), 32'd1);
    check({tag, " state play"},  32'(state), 32'd2);
    check({tag, " run"},         32'(run),   32'd1);
    tick();
    check({tag, " serve one cycle"}, 32'(serve), 32'd0);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; hard = 1'b0;
    goal = 1'b0; lose = 1'b0; bar_move_speed = 4'd5;

    // 1: reset values
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst state",      32'(state),      32'd0);
    check("rst run",        32'(run),        32'd0);
    check("rst serve",      32'(serve),      32'd0);
    check("rst game_over",  32'(game_over),  32'd0);
    check("rst score",      32'(score),      32'd0);
    check("rst lives",      32'(lives),      32'd0);
    check("rst level",      32'(level),      32'd0);
    check("rst ball_speed", 32'(ball_speed), 32'd1);
    check("rst bar_speed",  32'(bar_speed),  32'd5);

    // Holding start high does not retrigger; only the edge counts.
    start_game(1'b0);
    check("n start state", 32'(state), 32'd1);
    check("n start lives", 32'(lives), 32'd3);

    // 2: serve countdown
    do_serve("n1");

    // 3: ten goals -> one level
    pulse_goal(9);
    tick();
    check("9 goals score", 32'(score), 32'd9);
    check("9 goals level", 32'(level), 32'd0);
    pulse_goal(1);
    check("10 goals score",      32'(score),      32'd10);
    check("10 goals level",      32'(level),      32'd1);
    check("10 goals ball_speed", 32'(ball_speed), 32'd2);

    // 4: goal and lose together, lose wins
    goal = 1'b1; lose = 1'b1; tick();
    goal = 1'b0; lose = 1'b0;
    check("collide score", 32'(score), 32'd10);
    check("collide lives", 32'(lives), 32'd2);
    check("collide state", 32'(state), 32'd1);
    check("collide run",   32'(run),   32'd0);

    // Events outside their states are ignored.
    pulse_goal(1);
    check("goal in serve ignored", 32'(score), 32'd10);
    start_game(1'b1);
    check("start in serve ignored", 32'(lives), 32'd2);

    // Back to IDLE via reset for the hard game.
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2 state", 32'(state), 32'd0);

    // 5: hard game
    start_game(1'b1);
    check("h start lives",      32'(lives),      32'd1);
    check("h start ball_speed", 32'(ball_speed), 32'd3);
    do_serve("h1");
    pulse_goal(10);
    check("h 10 goals level",      32'(level),      32'd1);
    check("h 10 goals ball_speed", 32'(ball_speed), 32'd4);
    lose = 1'b1; tick(); lose = 1'b0;
    check("h lose state",     32'(state),     32'd3);
    check("h lose game_over", 32'(game_over), 32'd1);
    check("h lose lives",     32'(lives),     32'd0);
    check("h lose run",       32'(run),       32'd0);
    pulse_goal(1);
    check("goal in over ignored", 32'(score), 32'd10);
    frames(179);
    check("over held state", 32'(state), 32'd3);
    frames(1);
    check("over done state",     32'(state),     32'd0);
    check("over done game_over", 32'(game_over), 32'd0);
    check("over score held",     32'(score),     32'd10);
    check("over level held",     32'(level),     32'd1);

    // 6: bar speed clamp, then reset mid-play
    bar_move_speed = 4'd0; #1;
    check("bar_speed zero", 32'(bar_speed), 32'd1);
    bar_move_speed = 4'd15; #1;
    check("bar_speed max",  32'(bar_speed), 32'd15);
    start_game(1'b0);
    check("restart score cleared", 32'(score), 32'd0);
    check("restart lives",         32'(lives), 32'd3);
    do_serve("n2");
    pulse_goal(3);
    check("n2 score", 32'(score), 32'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid rst state", 32'(state), 32'd0);
    check("mid rst score", 32'(score), 32'd0);
    check("mid rst run",   32'(run),   32'd0);
    check("mid rst lives", 32'(lives), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
